// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage and its helpers.
package wb_pkg;

    localparam int unsigned WB_DATA_W     = 16;
    localparam int unsigned WB_REG_ADDR_W = 3;
    localparam int unsigned WB_CNT_W      = 16;

    // Writeback result source select.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Byte select plus sign/zero extension of a raw memory read word.
// Purely combinational; also used by the MEM-side misaligned-access checker.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              is_byte,
    input  logic              is_unsigned,
    input  logic              addr_lsb,
    output logic [DATA_W-1:0] data_out_c
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned EXT_W  = DATA_W - BYTE_W;

    logic [BYTE_W-1:0] byte_sel;
    logic              ext_bit;

    // Pick the addressed byte and extend it; words pass through untouched.
    always_comb begin
        byte_sel   = addr_lsb ? data_in[2*BYTE_W-1:BYTE_W] : data_in[BYTE_W-1:0];
        ext_bit    = is_unsigned ? 1'b0 : byte_sel[BYTE_W-1];
        data_out_c = data_in;
        if (is_byte) begin
            data_out_c = {{EXT_W{ext_bit}}, byte_sel};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB stage: selects the writeback result, registers the register-file
// write port, bypasses the pending write onto both decode read ports and
// counts retired instructions.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned REG_ADDR_W = WB_REG_ADDR_W,
    parameter int unsigned CNT_W      = WB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [1:0]            mem_wb_sel,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_load_data,
    input  logic                  mem_load_byte,
    input  logic                  mem_load_unsigned,
    input  logic                  mem_addr_lsb,
    input  logic [DATA_W-1:0]     mem_link_pc,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rd_addr_1,
    input  logic [REG_ADDR_W-1:0] rd_addr_2,
    input  logic [DATA_W-1:0]     gpr_data_1,
    input  logic [DATA_W-1:0]     gpr_data_2,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0]     reg_write_data,
    output logic [DATA_W-1:0]     fwd_data_1,
    output logic [DATA_W-1:0]     fwd_data_2,
    output logic [CNT_W-1:0]      retire_count,
    output logic                  wb_sel_err
);

    logic                  wb_valid_q,     wb_valid_d;
    logic                  wr_en_q,        wr_en_d;
    logic [REG_ADDR_W-1:0] wr_dest_q,      wr_dest_d;
    logic [DATA_W-1:0]     wr_data_q,      wr_data_d;
    logic [CNT_W-1:0]      retire_count_q, retire_count_d;
    logic                  sel_err_q,      sel_err_d;

    logic [DATA_W-1:0]     load_ext_c;
    logic                  capture_c;
    logic                  rsvd_c;

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .data_in     (mem_load_data),
        .is_byte     (mem_load_byte),
        .is_unsigned (mem_load_unsigned),
        .addr_lsb    (mem_addr_lsb),
        .data_out_c  (load_ext_c)
    );

    // Next-state: result mux, write qualification, sticky error, retire count.
    always_comb begin
        capture_c      = mem_valid & ~flush;
        rsvd_c         = (wb_sel_e'(mem_wb_sel) == WB_RSVD);

        wb_valid_d     = capture_c;
        wr_en_d        = capture_c & mem_reg_write & ~rsvd_c;
        wr_dest_d      = mem_dest;
        wr_data_d      = '0;
        sel_err_d      = sel_err_q | (capture_c & rsvd_c);
        retire_count_d = retire_count_q + CNT_W'(wb_valid_q);

        case (wb_sel_e'(mem_wb_sel))
            WB_ALU:  wr_data_d = mem_alu_result;
            WB_LOAD: wr_data_d = load_ext_c;
            WB_LINK: wr_data_d = mem_link_pc;
            default: wr_data_d = '0;
        endcase
    end

    // WB pipeline registers; reset drops any pending write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_dest_q      <= '0;
            wr_data_q      <= '0;
            retire_count_q <= '0;
            sel_err_q      <= 1'b0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wr_en_q        <= wr_en_d;
            wr_dest_q      <= wr_dest_d;
            wr_data_q      <= wr_data_d;
            retire_count_q <= retire_count_d;
            sel_err_q      <= sel_err_d;
        end
    end

    // Same-cycle bypass: the register file has not committed the pending write yet.
    always_comb begin
        fwd_data_1 = gpr_data_1;
        fwd_data_2 = gpr_data_2;
        if (wr_en_q && (wr_dest_q == rd_addr_1)) begin
            fwd_data_1 = wr_data_q;
        end
        if (wr_en_q && (wr_dest_q == rd_addr_2)) begin
            fwd_data_2 = wr_data_q;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign retire_count   = retire_count_q;
    assign wb_sel_err     = sel_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a behavioural 8 x 16 register file.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [2:0]  mem_dest;
    logic [1:0]  mem_wb_sel;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_load_data;
    logic        mem_load_byte;
    logic        mem_load_unsigned;
    logic        mem_addr_lsb;
    logic [15:0] mem_link_pc;
    logic        flush;
    logic [2:0]  rd_addr_1;
    logic [2:0]  rd_addr_2;
    logic [15:0] gpr_data_1;
    logic [15:0] gpr_data_2;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [15:0] fwd_data_1;
    logic [15:0] fwd_data_2;
    logic [15:0] retire_count;
    logic        wb_sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf [8];

    always #5 clk = ~clk;

    // Register file: synchronous write, asynchronous read, no reset.
    always @(posedge clk) begin
        if (reg_write_en) rf[reg_write_dest] <= reg_write_data;
    end
    assign gpr_data_1 = rf[rd_addr_1];
    assign gpr_data_2 = rf[rd_addr_2];

    wb_stage dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_reg_write     (mem_reg_write),
        .mem_dest          (mem_dest),
        .mem_wb_sel        (mem_wb_sel),
        .mem_alu_result    (mem_alu_result),
        .mem_load_data     (mem_load_data),
        .mem_load_byte     (mem_load_byte),
        .mem_load_unsigned (mem_load_unsigned),
        .mem_addr_lsb      (mem_addr_lsb),
        .mem_link_pc       (mem_link_pc),
        .flush             (flush),
        .rd_addr_1         (rd_addr_1),
        .rd_addr_2         (rd_addr_2),
        .gpr_data_1        (gpr_data_1),
        .gpr_data_2        (gpr_data_2),
        .reg_write_en      (reg_write_en),
        .reg_write_dest    (reg_write_dest),
        .reg_write_data    (reg_write_data),
        .fwd_data_1        (fwd_data_1),
        .fwd_data_2        (fwd_data_2),
        .retire_count      (retire_count),
        .wb_sel_err        (wb_sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i);
        rst = 1'b1; mem_valid = 1'b0; mem_reg_write = 1'b0; mem_dest = 3'd0;
        mem_wb_sel = 2'b00; mem_alu_result = 16'h0; mem_load_data = 16'h0;
        mem_load_byte = 1'b0; mem_load_unsigned = 1'b0; mem_addr_lsb = 1'b0;
        mem_link_pc = 16'h0; flush = 1'b0; rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;

        // Reset state
        step(); step();
        chk("rst_en",    32'(reg_write_en),   32'h0);
        chk("rst_dest",  32'(reg_write_dest), 32'h0);
        chk("rst_data",  32'(reg_write_data), 32'h0);
        chk("rst_count", 32'(retire_count),   32'h0);
        chk("rst_err",   32'(wb_sel_err),     32'h0);
        rst = 1'b0;

        // ALU write with bypass on port 1
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_dest = 3'd3;
        mem_wb_sel = 2'b00; mem_alu_result = 16'h1234; rd_addr_1 = 3'd3;
        step();
        chk("alu_en",    32'(reg_write_en),   32'h1);
        chk("alu_dest",  32'(reg_write_dest), 32'h3);
        chk("alu_data",  32'(reg_write_data), 32'h1234);
        chk("alu_fwd1",  32'(fwd_data_1),     32'h1234);
        chk("alu_gpr1_old", 32'(gpr_data_1),  32'hA003);
        chk("alu_count0", 32'(retire_count),  32'h0);
        mem_valid = 1'b0;
        step();
        chk("alu_rf_commit", 32'(gpr_data_1), 32'h1234);
        chk("alu_fwd1_rf",   32'(fwd_data_1), 32'h1234);
        chk("alu_count1",    32'(retire_count), 32'h1);

        // Byte/word load extension of 16'h80F0
        mem_valid = 1'b1; mem_dest = 3'd1; mem_wb_sel = 2'b01;
        mem_load_data = 16'h80F0; mem_load_byte = 1'b1;
        mem_load_unsigned = 1'b0; mem_addr_lsb = 1'b0;
        step();
        chk("ld_lo_s", 32'(reg_write_data), 32'hFFF0);
        chk("ld_count", 32'(retire_count),  32'h1);
        mem_addr_lsb = 1'b1;
        step();
        chk("ld_hi_s", 32'(reg_write_data), 32'hFF80);
        mem_load_unsigned = 1'b1;
        step();
        chk("ld_hi_u", 32'(reg_write_data), 32'h0080);
        mem_load_byte = 1'b0;
        step();
        chk("ld_word", 32'(reg_write_data), 32'h80F0);
        chk("ld_count4", 32'(retire_count), 32'h4);

        // Link, then the same instruction flushed
        mem_wb_sel = 2'b10; mem_link_pc = 16'h0042; mem_dest = 3'd7;
        step();
        chk("link_en",   32'(reg_write_en),   32'h1);
        chk("link_dest", 32'(reg_write_dest), 32'h7);
        chk("link_data", 32'(reg_write_data), 32'h0042);
        chk("link_count", 32'(retire_count),  32'h5);
        flush = 1'b1;
        step();
        chk("flush_en",  32'(reg_write_en),   32'h0);
        chk("flush_count_a", 32'(retire_count), 32'h6);
        step();
        chk("flush_count_b", 32'(retire_count), 32'h6);

        // Reserved select: no write, sticky error, still retires
        flush = 1'b0; mem_wb_sel = 2'b11; mem_dest = 3'd2; mem_alu_result = 16'hFFFF;
        step();
        chk("rsvd_en",   32'(reg_write_en),   32'h0);
        chk("rsvd_data", 32'(reg_write_data), 32'h0);
        chk("rsvd_err",  32'(wb_sel_err),     32'h1);
        mem_valid = 1'b0;
        step();
        chk("rsvd_count", 32'(retire_count),  32'h7);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rsvd_err_hold", 32'(wb_sel_err), 32'h1);
        end
        chk("rsvd_count_hold", 32'(retire_count), 32'h7);

        // Dual bypass to the same destination, then port independence
        mem_valid = 1'b1; mem_wb_sel = 2'b00; mem_dest = 3'd4; mem_alu_result = 16'hBEEF;
        rd_addr_1 = 3'd4; rd_addr_2 = 3'd4;
        step();
        chk("dual_fwd1", 32'(fwd_data_1), 32'hBEEF);
        chk("dual_fwd2", 32'(fwd_data_2), 32'hBEEF);
        rd_addr_2 = 3'd5;
        #1;
        chk("indep_fwd1", 32'(fwd_data_1), 32'hBEEF);
        chk("indep_fwd2", 32'(fwd_data_2), 32'hA005);

        // Reset mid-write to r5: dropped asynchronously, r5 never written
        mem_dest = 3'd5; mem_alu_result = 16'h5555; rd_addr_1 = 3'd5;
        step();
        chk("pre_rst_en",   32'(reg_write_en),   32'h1);
        chk("pre_rst_dest", 32'(reg_write_dest), 32'h5);
        mem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_en",    32'(reg_write_en),   32'h0);
        chk("arst_dest",  32'(reg_write_dest), 32'h0);
        chk("arst_data",  32'(reg_write_data), 32'h0);
        chk("arst_count", 32'(retire_count),   32'h0);
        chk("arst_err",   32'(wb_sel_err),     32'h0);
        step();
        chk("arst_r5", 32'(gpr_data_1), 32'hA005);
        rst = 1'b0;

        // Retire counter wrap
        mem_reg_write = 1'b0; mem_valid = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        mem_valid = 1'b0;
        step();
        chk("wrap_ffff", 32'(retire_count), 32'hFFFF);
        mem_valid = 1'b1;
        step();
        chk("wrap_hold", 32'(retire_count), 32'hFFFF);
        mem_valid = 1'b0;
        step();
        chk("wrap_zero", 32'(retire_count), 32'h0000);
        chk("wrap_r5",   32'(gpr_data_1),   32'hA005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
